image_frame_arbiter: RTL and testbench
======================================

Name: image_frame_arbiter

Overview:
- Shares one downstream image pipe (typically an image_fifo input) between two upstream image sources, with arbitration at frame granularity.
- A frame request arriving downstream is issued to one source at a time, chosen round-robin.
- The granted source's beats pass through combinationally until its stop beat is accepted; the grant then advances.
- Sits between camera/generator sources and a shared image_fifo or processing chain.

Parameters:
- IS, `IS_DEFAULT, image spec shared by all three image ports; the port width is `I_w(IS).
- FirstGrant, 0, source index (0 or 1) granted first after reset.
- TimeoutCycles, 1024, watchdog limit in clock cycles; used only when the optional feature is compiled in.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- image_in_0  inout  `I_w(IS)  source 0 image bus. Start/stop/data/valid/error flow in; ready/request/cancel flow out.
- image_in_1  inout  `I_w(IS)  source 1 image bus, same field directions as image_in_0.
- image_out  inout  `I_w(IS)  sink image bus. Start/stop/data/valid/error flow out; ready/request/cancel flow in.
- grant  out  1  index of the source currently selected.
- busy  out  1  high in REQUEST or TRANSFER state.

Behaviour:
- Clock and reset: one clock, `clock`; reset is asynchronous and active-high, port `reset`.
- Reset values: state=IDLE, grant=FirstGrant, busy=0. Both inputs see request=0, cancel=0, ready=0. image_out has valid=0, start=0, stop=0, data=0, error=0.
- IDLE:
  - All input ready/request outputs are 0; out valid=0.
  - When out request=1, go to REQUEST(grant).
- REQUEST(n):
  - Drive request=1 to source n only.
  - Source n ready = out ready.
  - A source-n beat with valid=1 and start=1 is passed to out in the same cycle (combinational, zero latency). If accepted (out ready=1), go to TRANSFER(n). If that beat also has stop=1, it is a single-beat frame: go straight to IDLE and toggle grant.
  - A source-n beat with valid=1 and start=0 is a stray beat: consumed (ready=1) and dropped (out valid=0).
- TRANSFER(n):
  - Request to source n is held at 1.
  - Out fields start/stop/data/valid/error come from source n; source n ready = out ready.
  - Accepted beat with stop=1 → IDLE, grant toggles.
- Non-granted source: ready=0, request=0, cancel=0 at all times.
- Error: out error = granted source's error in REQUEST/TRANSFER, 0 in IDLE.
- Cancel:
  - Out cancel is forwarded combinationally to the granted source in REQUEST/TRANSFER.
  - Next state is IDLE; grant toggles (the aborted frame counts as a turn).
  - Out valid is forced to 0 during the cancel cycle.
  - Out cancel in IDLE is ignored.
- Out request dropping mid-frame does not abort: the frame completes; the arbiter then stays IDLE.
- Back-to-back frames: stop accepted at cycle t → IDLE at t+1. If out request is still high, REQUEST(other) at t+2.
- Reset asserted mid-frame: immediately returns to reset values; the partial frame is abandoned.
- busy = (state != IDLE).

Optional Feature:
- Macro: IMAGE_FRAME_ARBITER_TIMEOUT_EN.
- With it defined:
  - A counter clears on state entry and on every accepted beat, and increments otherwise in REQUEST/TRANSFER.
  - At count == TimeoutCycles-1: assert cancel to the granted source for 1 cycle, drive out error=1 for that cycle, go to IDLE, toggle grant.
- Without it: no counter logic exists; a silent source holds the grant indefinitely.

Test Plan:
- Reset with FirstGrant=0 → grant=0, busy=0, in0/in1 request=0, out valid=0.
- Out request=1, out ready=1; source 0 sends a 4-beat frame 10,11,12,13 (start on 10, stop on 13) → out shows 10..13 with matching start/stop in the same cycles. IDLE follows; grant=1; source 1 request rises 2 cycles after the stop cycle.
- Out ready toggled 0/1 mid-frame from source 1 (data 20..27) → no beat lost or duplicated. Source 1 ready mirrors out ready. Source 0 ready=0 throughout.
- Source 0 granted and sends 3 beats without start, then start beat 30 → the stray beats are consumed with out valid=0; 30 appears with start=1.
- Out cancel pulse on the 3rd beat of a source-0 frame → source 0 cancel=1 that cycle. Next cycle state=IDLE, grant=1, out valid=0.
- (Timeout build, TimeoutCycles=16) Source 1 granted and silent → after 16 cycles, source 1 cancel pulses and out error=1 for 1 cycle; grant returns to 0.

Source files
------------

// File: rtl/image_frame_arbiter_if.sv
// Image bus bundle used by image_frame_arbiter. Forward fields carry a beat;
// ready/request/cancel flow back toward the source.
`ifndef IS_DEFAULT
`define IS_DEFAULT 8
`endif
`ifndef I_w
`define I_w(is) ((is) + 7)
`endif

interface image_frame_arbiter_if #(
  parameter int IS = `IS_DEFAULT
);
  logic          start;
  logic          stop;
  logic [IS-1:0] data;
  logic          valid;
  logic          error;
  logic          ready;
  logic          request;
  logic          cancel;

  modport arb_src (
    input  start, stop, data, valid, error,
    output ready, request, cancel
  );

  modport arb_sink (
    output start, stop, data, valid, error,
    input  ready, request, cancel
  );
endinterface

// File: rtl/image_frame_arbiter.sv
// Frame-granular round-robin arbiter sharing one image sink between two sources.
// Optional watchdog enabled by defining IMAGE_FRAME_ARBITER_TIMEOUT_EN.
`ifndef IS_DEFAULT
`define IS_DEFAULT 8
`endif

module image_frame_arbiter #(
  parameter int IS            = `IS_DEFAULT,
  parameter int FirstGrant    = 0,
  parameter int TimeoutCycles = 1024
) (
  input  logic                    clock,
  input  logic                    reset,
  image_frame_arbiter_if.arb_src  image_in_0,
  image_frame_arbiter_if.arb_src  image_in_1,
  image_frame_arbiter_if.arb_sink image_out,
  output logic                    grant,
  output logic                    busy
);

  typedef enum logic [1:0] {IDLE, REQUEST, TRANSFER} state_t;

  state_t        state, state_next;
  logic          turn_end;
  logic          active;
  logic          s_valid, s_start, s_stop, s_error;
  logic [IS-1:0] s_data;
  logic          src_ready;
  logic          beat_acc;
  logic          stop_acc;
  logic          start_acc;
  logic          timeout;
  logic          cancel_now;

  if (FirstGrant < 0 || FirstGrant > 1 || TimeoutCycles < 2) begin : g_bad_param
    $error("image_frame_arbiter: FirstGrant must be 0/1 and TimeoutCycles >= 2");
  end

  assign active = (state != IDLE);

  always_comb begin
    if (grant) begin
      s_valid = image_in_1.valid;
      s_start = image_in_1.start;
      s_stop  = image_in_1.stop;
      s_error = image_in_1.error;
      s_data  = image_in_1.data;
    end else begin
      s_valid = image_in_0.valid;
      s_start = image_in_0.start;
      s_stop  = image_in_0.stop;
      s_error = image_in_0.error;
      s_data  = image_in_0.data;
    end
  end

`ifdef IMAGE_FRAME_ARBITER_TIMEOUT_EN
  localparam int CW = $clog2(TimeoutCycles) + 1;
  logic [CW-1:0] count;

  // Idle time of the granted source; restarts on every state change or accepted beat
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (!active || state_next != state || beat_acc) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign timeout = active && (count == CW'(TimeoutCycles - 1));
`else
  assign timeout = 1'b0;
`endif

  assign cancel_now = active && (image_out.cancel || timeout);

  // Stray (start-less) beats in REQUEST are swallowed regardless of the sink
  always_comb begin
    src_ready = 1'b0;
    if (state == REQUEST) begin
      src_ready = (s_valid && !s_start) ? 1'b1 : image_out.ready;
    end else if (state == TRANSFER) begin
      src_ready = image_out.ready;
    end
    if (cancel_now) begin
      src_ready = 1'b0;
    end
  end

  assign beat_acc  = s_valid && src_ready;
  assign start_acc = (state == REQUEST) && beat_acc && s_start;
  assign stop_acc  = beat_acc && s_stop && ((state == TRANSFER) || start_acc);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      grant <= FirstGrant[0];
    end else begin
      state <= state_next;
      if (turn_end) begin
        grant <= ~grant;
      end
    end
  end

  always_comb begin
    state_next = state;
    turn_end   = 1'b0;
    case (state)
      IDLE: begin
        if (image_out.request) state_next = REQUEST;
      end
      REQUEST, TRANSFER: begin
        if (cancel_now || stop_acc) begin
          state_next = IDLE;
          turn_end   = 1'b1;
        end else if (start_acc) begin
          state_next = TRANSFER;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    image_out.valid    = active && s_valid && !cancel_now && ((state == TRANSFER) || s_start);
    image_out.start    = active && s_start;
    image_out.stop     = active && s_stop;
    image_out.data     = active ? s_data : '0;
    image_out.error    = active && (s_error || timeout);
    image_in_0.request = active && !grant;
    image_in_0.ready   = src_ready && !grant;
    image_in_0.cancel  = cancel_now && !grant;
    image_in_1.request = active && grant;
    image_in_1.ready   = src_ready && grant;
    image_in_1.cancel  = cancel_now && grant;
    busy               = active;
  end

endmodule

// File: tb/tb_image_frame_arbiter.sv
// Testbench for image_frame_arbiter: per-cycle vector table plus a beat scoreboard.
module tb_image_frame_arbiter;
  localparam int DW = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic grant, busy;

  image_frame_arbiter_if #(.IS(DW)) src0 ();
  image_frame_arbiter_if #(.IS(DW)) src1 ();
  image_frame_arbiter_if #(.IS(DW)) snk ();

  image_frame_arbiter #(.IS(DW), .FirstGrant(0), .TimeoutCycles(16)) dut (
    .clock(clock), .reset(reset),
    .image_in_0(src0), .image_in_1(src1), .image_out(snk),
    .grant(grant), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    string      name;
    bit         req, ordy, ocan, err;
    bit         v0, st0, sp0;
    logic [7:0] d0;
    bit         v1, st1, sp1;
    logic [7:0] d1;
    logic [9:0] exp;  // {grant,busy,ovalid,rdy0,rdy1,req0,req1,can0,can1,oerr}
  } vec_t;

  typedef struct {
    logic [7:0] d;
    bit         st, sp;
  } beat_t;

  vec_t  vecs[$];
  beat_t sbq[$];
  int    checks = 0;
  int    errors = 0;

  function automatic vec_t mk(string n, bit req, bit ordy, bit ocan, bit err,
                              bit v0, bit st0, bit sp0, logic [7:0] d0,
                              bit v1, bit st1, bit sp1, logic [7:0] d1, logic [9:0] exp);
    vec_t v;
    v.name = n; v.req = req; v.ordy = ordy; v.ocan = ocan; v.err = err;
    v.v0 = v0; v.st0 = st0; v.sp0 = sp0; v.d0 = d0;
    v.v1 = v1; v.st1 = st1; v.sp1 = sp1; v.d1 = d1;
    v.exp = exp;
    return v;
  endfunction

  function automatic logic [9:0] observe();
    return {grant, busy, snk.valid, src0.ready, src1.ready,
            src0.request, src1.request, src0.cancel, src1.cancel, snk.error};
  endfunction

  task automatic drive(vec_t v);
    snk.request = v.req; snk.ready = v.ordy; snk.cancel = v.ocan;
    src0.valid = v.v0; src0.start = v.st0; src0.stop = v.sp0; src0.data = v.d0; src0.error = v.err;
    src1.valid = v.v1; src1.start = v.st1; src1.stop = v.sp1; src1.data = v.d1; src1.error = v.err;
  endtask

  task automatic check_bits(string n, logic [9:0] act, logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%b want=%b", n, act, exp);
    end
  endtask

  task automatic sb_check(string n);
    beat_t b;
    if (snk.valid && snk.ready) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL %s_unexpected_beat got=%0d want=none", n, snk.data);
      end else begin
        b = sbq.pop_front();
        if ({snk.data, snk.start, snk.stop} !== {b.d, b.st, b.sp}) begin
          errors++;
          $display("FAIL %s_beat got=%0d/%b/%b want=%0d/%b/%b", n,
                   snk.data, snk.start, snk.stop, b.d, b.st, b.sp);
        end
      end
    end else if (sbq.size() > 0) begin
      checks++;
      errors++;
      b = sbq.pop_front();
      $display("FAIL %s_missing_beat got=none want=%0d", n, b.d);
    end
  endtask

  task automatic apply(vec_t v);
    beat_t b;
    @(posedge clock);
    #1;
    drive(v);
    if (v.exp[7] && v.ordy) begin
      b.d  = v.exp[9] ? v.d1  : v.d0;
      b.st = v.exp[9] ? v.st1 : v.st0;
      b.sp = v.exp[9] ? v.sp1 : v.sp0;
      sbq.push_back(b);
    end
    #2;
    check_bits(v.name, observe(), v.exp);
    sb_check(v.name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "simulation bound exceeded");
  end

  initial begin
    int hit;
    logic hit_err, hit_valid;

    drive(mk("zero", 0,0,0,0, 0,0,0,0, 0,0,0,0, 10'b0));
    repeat (3) @(posedge clock);
    #3;
    check_bits("reset_ctl", observe(), 10'b0_0_0_00_00_00_0);
    check_bits("reset_fields", {snk.start, snk.stop, snk.data}, 10'b0);
    @(posedge clock);
    #1 reset = 1'b0;

    // Frame from source 0, then source 1 with sink back-pressure
    vecs.push_back(mk("idle_req",      1,1,0,0, 0,0,0,0,   0,0,0,0,  10'b0_0_0_00_00_00_0));
    vecs.push_back(mk("f0_b10",        1,1,0,0, 1,1,0,10,  0,0,0,0,  10'b0_1_1_10_10_00_0));
    vecs.push_back(mk("f0_b11",        1,1,0,0, 1,0,0,11,  1,1,0,99, 10'b0_1_1_10_10_00_0));
    vecs.push_back(mk("f0_b12",        1,1,0,0, 1,0,0,12,  0,0,0,0,  10'b0_1_1_10_10_00_0));
    vecs.push_back(mk("f0_b13",        1,1,0,0, 1,0,1,13,  0,0,0,0,  10'b0_1_1_10_10_00_0));
    vecs.push_back(mk("idle_g1",       1,1,0,0, 0,0,0,0,   0,0,0,0,  10'b1_0_0_00_00_00_0));
    vecs.push_back(mk("f1_b20",        1,1,0,0, 0,0,0,0,   1,1,0,20, 10'b1_1_1_01_01_00_0));
    vecs.push_back(mk("f1_b21_stall",  1,0,0,0, 0,0,0,0,   1,0,0,21, 10'b1_1_1_00_01_00_0));
    vecs.push_back(mk("f1_b21",        1,1,0,0, 0,0,0,0,   1,0,0,21, 10'b1_1_1_01_01_00_0));
    vecs.push_back(mk("f1_b22",        1,1,0,0, 1,1,0,5,   1,0,0,22, 10'b1_1_1_01_01_00_0));
    vecs.push_back(mk("f1_b23_stall",  1,0,0,0, 0,0,0,0,   1,0,0,23, 10'b1_1_1_00_01_00_0));
    vecs.push_back(mk("f1_b23",        1,1,0,0, 0,0,0,0,   1,0,0,23, 10'b1_1_1_01_01_00_0));
    vecs.push_back(mk("f1_b24",        1,1,0,0, 0,0,0,0,   1,0,0,24, 10'b1_1_1_01_01_00_0));
    vecs.push_back(mk("f1_b25_stall",  1,0,0,0, 0,0,0,0,   1,0,0,25, 10'b1_1_1_00_01_00_0));
    vecs.push_back(mk("f1_b25",        1,1,0,0, 0,0,0,0,   1,0,0,25, 10'b1_1_1_01_01_00_0));
    vecs.push_back(mk("f1_b26",        1,1,0,0, 0,0,0,0,   1,0,0,26, 10'b1_1_1_01_01_00_0));
    vecs.push_back(mk("f1_b27_stall",  1,0,0,0, 0,0,0,0,   1,0,1,27, 10'b1_1_1_00_01_00_0));
    vecs.push_back(mk("f1_b27",        1,1,0,0, 0,0,0,0,   1,0,1,27, 10'b1_1_1_01_01_00_0));
    // Stray beats before a start, then a cancel on the third beat
    vecs.push_back(mk("idle_g0",       1,1,0,0, 0,0,0,0,   0,0,0,0,  10'b0_0_0_00_00_00_0));
    vecs.push_back(mk("stray1",        1,1,0,0, 1,0,0,1,   0,0,0,0,  10'b0_1_0_10_10_00_0));
    vecs.push_back(mk("stray2",        1,0,0,0, 1,0,0,2,   0,0,0,0,  10'b0_1_0_10_10_00_0));
    vecs.push_back(mk("stray3",        1,1,0,0, 1,0,1,3,   0,0,0,0,  10'b0_1_0_10_10_00_0));
    vecs.push_back(mk("f0_b30",        1,1,0,0, 1,1,0,30,  0,0,0,0,  10'b0_1_1_10_10_00_0));
    vecs.push_back(mk("f0_b31",        1,1,0,0, 1,0,0,31,  0,0,0,0,  10'b0_1_1_10_10_00_0));
    vecs.push_back(mk("f0_cancel",     1,1,1,0, 1,0,0,32,  0,0,0,0,  10'b0_1_0_00_10_10_0));
    vecs.push_back(mk("idle_can_ign",  0,1,1,0, 0,0,0,0,   0,0,0,0,  10'b1_0_0_00_00_00_0));
    // Request dropped mid-frame, error pass-through, single-beat frame
    vecs.push_back(mk("idle_req1",     1,1,0,0, 0,0,0,0,   0,0,0,0,  10'b1_0_0_00_00_00_0));
    vecs.push_back(mk("f1_b40_drop",   0,1,0,0, 0,0,0,0,   1,1,0,40, 10'b1_1_1_01_01_00_0));
    vecs.push_back(mk("f1_b41_err",    0,1,0,1, 0,0,0,0,   1,0,0,41, 10'b1_1_1_01_01_00_1));
    vecs.push_back(mk("f1_b42_stop",   0,1,0,0, 0,0,0,0,   1,0,1,42, 10'b1_1_1_01_01_00_0));
    vecs.push_back(mk("idle_err_mask", 0,1,0,1, 0,0,0,0,   0,0,0,0,  10'b0_0_0_00_00_00_0));
    vecs.push_back(mk("idle_hold",     1,1,0,0, 0,0,0,0,   0,0,0,0,  10'b0_0_0_00_00_00_0));
    vecs.push_back(mk("f0_single",     1,1,0,0, 1,1,1,50,  0,0,0,0,  10'b0_1_1_10_10_00_0));
    vecs.push_back(mk("idle_single",   0,1,0,0, 0,0,0,0,   0,0,0,0,  10'b1_0_0_00_00_00_0));

    foreach (vecs[i]) apply(vecs[i]);

    // Reset asserted in the middle of a source-1 frame
    apply(mk("rst_req",  1,1,0,0, 0,0,0,0, 0,0,0,0,  10'b1_0_0_00_00_00_0));
    apply(mk("rst_b60",  1,1,0,0, 0,0,0,0, 1,1,0,60, 10'b1_1_1_01_01_00_0));
    apply(mk("rst_b61",  1,1,0,0, 0,0,0,0, 1,0,0,61, 10'b1_1_1_01_01_00_0));
    #1 reset = 1'b1;
    #1 check_bits("rst_midframe", observe(), 10'b0_0_0_00_00_00_0);
    drive(mk("zero", 0,0,0,0, 0,0,0,0, 0,0,0,0, 10'b0));
    @(posedge clock);
    #1 reset = 1'b0;
    apply(mk("post_rst_idle", 0,1,0,0, 0,0,0,0, 0,0,0,0, 10'b0_0_0_00_00_00_0));

`ifdef IMAGE_FRAME_ARBITER_TIMEOUT_EN
    // Source 1 granted but silent: watchdog fires on its 16th cycle
    apply(mk("to_req",    1,1,0,0, 0,0,0,0,   0,0,0,0, 10'b0_0_0_00_00_00_0));
    apply(mk("to_single", 1,1,0,0, 1,1,1,70,  0,0,0,0, 10'b0_1_1_10_10_00_0));
    apply(mk("to_idle",   1,1,0,0, 0,0,0,0,   0,0,0,0, 10'b1_0_0_00_00_00_0));
    hit = -1;
    hit_err = 1'b0;
    hit_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock);
      #3;
      if (src1.cancel) begin
        hit = i;
        hit_err = snk.error;
        hit_valid = snk.valid;
        break;
      end
    end
    checks++;
    if (hit != 15 || hit_err !== 1'b1 || hit_valid !== 1'b0) begin
      errors++;
      $display("FAIL timeout_fire got=cycle%0d/err%b/vld%b want=cycle15/err1/vld0",
               hit, hit_err, hit_valid);
    end
    @(posedge clock);
    #3;
    check_bits("timeout_after", {7'b0, grant, busy, src1.cancel}, 10'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
